ahb_slave_mem: RTL and testbench

AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

---
 rtl/amba_pkg.sv | 52 +++++
 rtl/ahb_mem_array.sv | 38 +++
 rtl/ahb_slave_mem.sv | 131 +++++++++++++
 tb/tb_ahb_slave_mem.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/amba_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : amba_pkg
//  Description : Shared AHB-Lite encodings, default bus geometry and the
//                slave-memory state type, plus the byte-lane decode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package amba_pkg;

    localparam int DWIDTH     = 32;
    localparam int AWIDTH     = 32;
    localparam int MEM_HEIGHT = 1024;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ERR1 = 2'b10,
        ST_ERR2 = 2'b11
    } slave_state_t;

    // Byte lanes touched by a legal transfer on a 32-bit little-endian bus.
    function automatic logic [3:0] lane_enables(input logic [2:0] size, input logic [1:0] lo);
        logic [3:0] be;
        be = 4'b0000;
        if (size == HSIZE_BYTE) begin
            be = 4'b0001 << lo;
        end else if (size == HSIZE_HALF) begin
            be = lo[1] ? 4'b1100 : 4'b0011;
        end else if (size == HSIZE_WORD) begin
            be = 4'b1111;
        end
        return be;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_mem_array
//  Description : MEM_HEIGHT x DWIDTH storage with byte-enable synchronous
//                write and combinational read on a shared word index.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_mem_array #(
    parameter  int DWIDTH     = 32,
    parameter  int MEM_HEIGHT = 1024,
    localparam int IDX_W      = $clog2(MEM_HEIGHT),
    localparam int NBYTES     = DWIDTH / 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [NBYTES-1:0] be,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DWIDTH-1:0] wdata,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem [MEM_HEIGHT];

    // Byte-lane write; contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule
`default_nettype wire

// File: rtl/ahb_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_slave_mem
//  Description : AHB-Lite memory slave with configurable wait states and the
//                two-cycle ERROR response for out-of-range or misaligned
//                transfers.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_slave_mem #(
    parameter int DWIDTH      = amba_pkg::DWIDTH,
    parameter int AWIDTH      = amba_pkg::AWIDTH,
    parameter int MEM_HEIGHT  = amba_pkg::MEM_HEIGHT,
    parameter int WAIT_STATES = 0
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [AWIDTH-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [DWIDTH-1:0] HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [DWIDTH-1:0] HRDATA
);

    import amba_pkg::*;

    localparam int IDX_W  = $clog2(MEM_HEIGHT);
    localparam int NBYTES = DWIDTH / 8;
    localparam logic [AWIDTH-3:0] WORD_LIMIT = (AWIDTH-2)'(MEM_HEIGHT);

    slave_state_t      state;
    logic [1:0]        wait_cnt;
    logic              dp_valid;   // an OKAY transfer owns the current data phase
    logic              dp_write;
    logic [IDX_W-1:0]  dp_word;
    logic [1:0]        dp_lo;
    logic [2:0]        dp_size;

    htrans_t           trans;
    logic              ready_out;
    logic              accept;
    logic              addr_err;
    logic              mem_we;
    logic [NBYTES-1:0] byte_en;
    logic [DWIDTH-1:0] mem_rdata;

    assign trans     = htrans_t'(HTRANS);
    assign ready_out = (state == ST_IDLE) || (state == ST_ERR2);
    // Only sample a new address phase when our own data phase is completing.
    assign accept    = HSEL && HREADY && ready_out &&
                       ((trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ));

    // Classify the presented address phase as OKAY or ERROR.
    always_comb begin
        addr_err = 1'b0;
        if (HADDR[AWIDTH-1:2] >= WORD_LIMIT)                 addr_err = 1'b1;
        if (HSIZE > HSIZE_WORD)                              addr_err = 1'b1;
        if ((HSIZE == HSIZE_HALF) && HADDR[0])               addr_err = 1'b1;
        if ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00))  addr_err = 1'b1;
    end

    // Transfer FSM: address capture, wait counting and the ERROR sequence.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= ST_IDLE;
            wait_cnt <= 2'd0;
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_word  <= '0;
            dp_lo    <= 2'b00;
            dp_size  <= 3'b000;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        state <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                ST_ERR1: begin
                    state <= ST_ERR2;
                end
                default: begin
                    // IDLE and ERR2 both end a data phase and may take a new one.
                    state    <= ST_IDLE;
                    dp_valid <= 1'b0;
                    if (accept) begin
                        dp_write <= HWRITE;
                        dp_word  <= HADDR[IDX_W+1:2];
                        dp_lo    <= HADDR[1:0];
                        dp_size  <= HSIZE;
                        dp_valid <= !addr_err;
                        if (addr_err) begin
                            state <= ST_ERR1;
                        end else if (WAIT_STATES > 0) begin
                            state    <= ST_WAIT;
                            wait_cnt <= 2'(WAIT_STATES - 1);
                        end
                    end
                end
            endcase
        end
    end

    // Writes commit only on the edge that closes an OKAY data phase.
    assign mem_we  = dp_valid && dp_write && (state == ST_IDLE);
    assign byte_en = NBYTES'(lane_enables(dp_size, dp_lo));

    ahb_mem_array #(
        .DWIDTH     (DWIDTH),
        .MEM_HEIGHT (MEM_HEIGHT)
    ) u_mem (
        .clk   (HCLK),
        .we    (mem_we),
        .be    (byte_en),
        .addr  (dp_word),
        .wdata (HWDATA),
        .rdata (mem_rdata)
    );

    assign HREADYOUT = ready_out;
    assign HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA    = (dp_valid && !dp_write) ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_ahb_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_slave_mem
//  Description : Scoreboard bench for ahb_slave_mem with zero and two wait
//                states, error responses, ignored phases and mid-wait reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_slave_mem;

    logic        HCLK;
    logic        HRESETn;
    logic        bus_sel;
    logic        dsel;       // 0: zero-wait instance, 1: two-wait instance
    logic        hold;       // forces HREADY low when cleared
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;

    logic        hsel0, hsel2, hready0, hready2;
    logic        ro0, ro2, resp0, resp2;
    logic [31:0] rd0, rd2;
    logic        m_sel, m_hready, m_ready, m_resp;
    logic [31:0] m_rdata;

    assign hsel0    = bus_sel && !dsel;
    assign hsel2    = bus_sel && dsel;
    assign hready0  = ro0 && hold;
    assign hready2  = ro2 && hold;
    assign m_sel    = dsel ? hsel2   : hsel0;
    assign m_hready = dsel ? hready2 : hready0;
    assign m_ready  = dsel ? ro2     : ro0;
    assign m_resp   = dsel ? resp2   : resp0;
    assign m_rdata  = dsel ? rd2     : rd0;

    ahb_slave_mem #(.WAIT_STATES(0)) u_dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel0), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HREADY(hready0), .HREADYOUT(ro0), .HRESP(resp0), .HRDATA(rd0)
    );

    ahb_slave_mem #(.WAIT_STATES(2)) u_dut2 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel2), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HREADY(hready2), .HREADYOUT(ro2), .HRESP(resp2), .HRDATA(rd2)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    typedef struct {
        logic [31:0] rdata;
        logic        resp;
        int          waits;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   in_dp;
    int   low_cnt;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the expectation at acceptance, checks every data-phase cycle.
    initial begin
        in_dp   = 1'b0;
        low_cnt = 0;
        forever begin
            @(negedge HCLK);
            if (!HRESETn) begin
                in_dp = 1'b0;
            end else begin
                if (in_dp) begin
                    if (!m_ready) begin
                        low_cnt++;
                        check({cur.name, " wait-cycle hresp"}, 32'(m_resp), 32'(cur.resp));
                        check({cur.name, " wait-cycle hrdata"}, m_rdata, cur.rdata);
                        if (low_cnt > 8) begin
                            check({cur.name, " data phase timeout"}, 32'(low_cnt), 32'(cur.waits));
                            in_dp = 1'b0;
                        end
                    end else begin
                        check({cur.name, " low cycles"}, 32'(low_cnt), 32'(cur.waits));
                        check({cur.name, " hresp"}, 32'(m_resp), 32'(cur.resp));
                        check({cur.name, " hrdata"}, m_rdata, cur.rdata);
                        in_dp = 1'b0;
                    end
                end else begin
                    check("idle hreadyout", 32'(m_ready), 32'd1);
                    check("idle hresp", 32'(m_resp), 32'd0);
                    check("idle hrdata", m_rdata, 32'd0);
                end
                if (!in_dp && m_sel && m_hready && HTRANS[1]) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected transfer accepted", 32'd1, 32'd0);
                    end else begin
                        cur     = exp_q.pop_front();
                        in_dp   = 1'b1;
                        low_cnt = 0;
                    end
                end
            end
        end
    end

    task automatic bus_idle();
        bus_sel = 1'b0;
        HTRANS  = 2'b00;
        HWRITE  = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    // Drive one address phase, wait for acceptance, then present its write data.
    task automatic issue(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                         input logic [1:0] tr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input bit exp_err, input string name);
        exp_t e;
        bit   got;
        e.rdata = exp_rd;
        e.resp  = exp_err;
        e.waits = exp_err ? 1 : (dsel ? 2 : 0);
        e.name  = name;
        exp_q.push_back(e);
        bus_sel = 1'b1;
        HTRANS  = tr;
        HADDR   = addr;
        HWRITE  = wr;
        HSIZE   = size;
        got     = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge HCLK);
            if (m_hready) got = 1'b1;
        end
        if (!got) check({name, " address phase timeout"}, 32'd0, 32'd1);
        @(posedge HCLK);
        #1;
        HWDATA = wdata;
    endtask

    task automatic check_reset(input string tag);
        check({tag, " dut0 hreadyout"}, 32'(ro0), 32'd1);
        check({tag, " dut0 hresp"}, 32'(resp0), 32'd0);
        check({tag, " dut0 hrdata"}, rd0, 32'd0);
        check({tag, " dut2 hreadyout"}, 32'(ro2), 32'd1);
        check({tag, " dut2 hresp"}, 32'(resp2), 32'd0);
        check({tag, " dut2 hrdata"}, rd2, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BAD = 3'b011;
    localparam logic [1:0] NS = 2'b10, SQ = 2'b11;

    initial begin
        HRESETn = 1'b0;
        dsel    = 1'b0;
        hold    = 1'b1;
        HADDR   = '0;
        HSIZE   = 3'b000;
        HWDATA  = '0;
        bus_idle();
        #3;
        check_reset("power-on reset");
        cycles(2);
        HRESETn = 1'b1;
        cycles(2);

        // Zero-wait instance: basic word, sub-word and error traffic.
        issue(1, 32'h10, W, NS, 32'hDEADBEEF, 32'h0, 0, "wr word 0x10");
        issue(0, 32'h10, W, NS, 32'h0, 32'hDEADBEEF, 0, "rd word 0x10");
        issue(1, 32'h10, W, NS, 32'h0, 32'h0, 0, "clear 0x10");
        issue(1, 32'h11, B, NS, 32'h0000AA00, 32'h0, 0, "wr byte 0x11");
        issue(0, 32'h10, W, NS, 32'h0, 32'h0000AA00, 0, "rd after byte");
        issue(1, 32'h12, H, NS, 32'h12340000, 32'h0, 0, "wr half 0x12");
        issue(0, 32'h10, W, NS, 32'h0, 32'h1234AA00, 0, "rd after half");
        issue(1, 32'h13, B, SQ, 32'h55000000, 32'h0, 0, "wr byte lane3");
        issue(0, 32'h10, W, SQ, 32'h0, 32'h5534AA00, 0, "rd after lane3");
        issue(1, 32'h0,  W, NS, 32'h11111111, 32'h0, 0, "wr word 0x0");
        issue(1, 32'h2,  W, NS, 32'hFFFFFFFF, 32'h0, 1, "wr word 0x2 misaligned");
        issue(0, 32'h2,  W, NS, 32'h0, 32'h0, 1, "rd word 0x2 misaligned");
        issue(1, 32'h1,  H, NS, 32'hFFFFFFFF, 32'h0, 1, "wr half 0x1 misaligned");
        issue(0, 32'h1,  H, NS, 32'h0, 32'h0, 1, "rd half 0x1 misaligned");
        issue(0, 32'h0,  BAD, NS, 32'h0, 32'h0, 1, "rd hsize 011");
        issue(1, 32'h1000, W, NS, 32'hFFFFFFFF, 32'h0, 1, "wr 0x1000 out of range");
        issue(0, 32'h1000, W, NS, 32'h0, 32'h0, 1, "rd 0x1000 out of range");
        issue(0, 32'h0,  W, NS, 32'h0, 32'h11111111, 0, "rd 0x0 after errors");
        issue(1, 32'hFFC, W, NS, 32'hCAFEF00D, 32'h0, 0, "wr last word");
        issue(0, 32'hFFC, W, SQ, 32'h0, 32'hCAFEF00D, 0, "rd last word");
        bus_idle();
        cycles(3);

        // Phases that must not start a transfer.
        HADDR  = 32'h10;
        HSIZE  = W;
        HWRITE = 1'b1;
        HWDATA = 32'hFFFFFFFF;
        HTRANS = NS;
        cycles(3);
        bus_sel = 1'b1;
        HTRANS  = 2'b01;
        cycles(3);
        HTRANS  = 2'b00;
        cycles(2);
        hold    = 1'b0;
        HTRANS  = NS;
        cycles(3);
        bus_idle();
        hold = 1'b1;
        cycles(2);
        issue(0, 32'h10, W, NS, 32'h0, 32'h5534AA00, 0, "rd 0x10 after ignored phases");
        bus_idle();
        cycles(3);

        // Two-wait instance: wait timing, back-to-back writes, reset mid-wait.
        dsel = 1'b1;
        cycles(1);
        issue(1, 32'h20, W, NS, 32'hA5A5A5A5, 32'h0, 0, "ws2 wr 0x20");
        issue(0, 32'h20, W, NS, 32'h0, 32'hA5A5A5A5, 0, "ws2 rd 0x20");
        issue(1, 32'h2C, W, NS, 32'h77777777, 32'h0, 0, "ws2 preload 0x2C");
        issue(1, 32'h24, W, NS, 32'h00000001, 32'h0, 0, "ws2 wr 0x24");
        issue(1, 32'h28, W, NS, 32'h00000002, 32'h0, 0, "ws2 wr 0x28");
        issue(1, 32'h2C, W, NS, 32'h00000033, 32'h0, 0, "ws2 aborted wr 0x2C");
        bus_idle();
        @(negedge HCLK);
        #2;
        HRESETn = 1'b0;
        #1;
        check_reset("reset mid-wait");
        cycles(2);
        HRESETn = 1'b1;
        cycles(2);
        issue(0, 32'h24, W, NS, 32'h0, 32'h00000001, 0, "ws2 rd 0x24 after reset");
        issue(0, 32'h28, W, NS, 32'h0, 32'h00000002, 0, "ws2 rd 0x28 after reset");
        issue(0, 32'h2C, W, NS, 32'h0, 32'h77777777, 0, "ws2 rd 0x2C aborted");
        issue(0, 32'h1000, W, NS, 32'h0, 32'h0, 1, "ws2 rd 0x1000 out of range");
        bus_idle();
        cycles(6);

        check("expectation queue drained", 32'(exp_q.size()), 32'd0);
        check("no data phase outstanding", 32'(in_dp), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
